// File: rtl/count_display_driver_pkg.sv
// Shared constants for the counter display path.
// Glyph codes, segment patterns and digit slot numbers.
package count_display_driver_pkg;

  typedef enum logic [3:0] {
    GLY_0     = 4'd0,
    GLY_1     = 4'd1,
    GLY_2     = 4'd2,
    GLY_3     = 4'd3,
    GLY_4     = 4'd4,
    GLY_5     = 4'd5,
    GLY_6     = 4'd6,
    GLY_7     = 4'd7,
    GLY_8     = 4'd8,
    GLY_9     = 4'd9,
    GLY_U     = 4'd10,
    GLY_D     = 4'd11,
    GLY_BLANK = 4'd15
  } glyph_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_SPARE = 2'd2;
  localparam logic [1:0] DIG_MODE  = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/count_display_driver_glyph_decode.sv
// Glyph code to active-low 7-segment pattern.
// Purely combinational; unknown codes render blank.
module seg7_glyph_decode
  import count_display_driver_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GLY_0:   seg = SEG_0;
      GLY_1:   seg = SEG_1;
      GLY_2:   seg = SEG_2;
      GLY_3:   seg = SEG_3;
      GLY_4:   seg = SEG_4;
      GLY_5:   seg = SEG_5;
      GLY_6:   seg = SEG_6;
      GLY_7:   seg = SEG_7;
      GLY_8:   seg = SEG_8;
      GLY_9:   seg = SEG_9;
      GLY_U:   seg = SEG_U;
      GLY_D:   seg = SEG_D;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Multiplexed 4-digit display of a 4-bit counter value
// plus a direction glyph, sampled once per frame.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit LEADING_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       mode,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    scan;
  logic [3:0]    snap_count;
  logic          snap_mode;
  logic          tens;
  logic [3:0]    units;
  logic [3:0]    glyph;
  logic [6:0]    seg_d;

  assign tick = (presc == PMAX);

  // Snapshot only on the 3->0 scan transition for coherent frames
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      scan       <= DIG_UNITS;
      snap_count <= 4'd0;
      snap_mode  <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        scan <= scan + 2'd1;
        if (scan == DIG_MODE) begin
          snap_count <= count;
          snap_mode  <= mode;
        end
      end
    end
  end

  assign tens  = (snap_count >= 4'd10);
  assign units = tens ? snap_count - 4'd10 : snap_count;

  always_comb begin
    glyph = GLY_BLANK;
    unique case (1'b1)
      (scan == DIG_UNITS): glyph = units;
      (scan == DIG_TENS):
        if (tens)               glyph = GLY_1;
        else if (LEADING_BLANK) glyph = GLY_BLANK;
        else                    glyph = GLY_0;
      (scan == DIG_SPARE): glyph = GLY_BLANK;
      (scan == DIG_MODE):  glyph = snap_mode ? GLY_U : GLY_D;
    endcase
  end

  seg7_glyph_decode u_decode (
    .glyph (glyph),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (enable) begin
        an  <= ~(4'b0001 << scan);
        seg <= seg_d;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver, REFRESH_DIV = 4,
// one instance per LEADING_BLANK setting.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic       mode = 1'b1;
  logic       enable = 1'b1;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;

  count_display_driver #(
    .REFRESH_DIV   (4),
    .LEADING_BLANK (1'b1)
  ) u_lb1 (
    .clk    (clk),
    .reset  (reset),
    .count  (count),
    .mode   (mode),
    .enable (enable),
    .seg    (seg_a),
    .an     (an_a),
    .dp     (dp_a)
  );

  count_display_driver #(
    .REFRESH_DIV   (4),
    .LEADING_BLANK (1'b0)
  ) u_lb0 (
    .clk    (clk),
    .reset  (reset),
    .count  (count),
    .mode   (mode),
    .enable (enable),
    .seg    (seg_b),
    .an     (an_b),
    .dp     (dp_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release; after edge k the shown slot is (k-1)/4 mod 4
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target);
    int k;
    k = 0;
    while (an_a !== target && k < 40) begin
      step(1);
      k++;
    end
    chk(tag, {4'b0, an_a}, {4'b0, target});
  endtask

  task automatic frame(input string tag);
    wait_an({tag, "_s3"}, 4'b0111);
    wait_an({tag, "_s0"}, 4'b1110);
  endtask

  function automatic logic [3:0] exp_an();
    int s;
    s = ((cyc - 1) / 4) % 4;
    return ~(4'b0001 << s);
  endfunction

  initial begin
    reset = 1'b1;
    step(3);
    chk("rst_an", {4'b0, an_a}, 8'b1111);
    chk("rst_seg", {1'b0, seg_a}, 8'b1111111);
    chk("rst_dp", {7'b0, dp_a}, 8'd1);
    chk("rst_an_b", {4'b0, an_b}, 8'b1111);

    reset = 1'b0;
    step(1);
    chk("rel_an", {4'b0, an_a}, 8'b1110);
    chk("rel_seg", {1'b0, seg_a}, 8'b1000000);
    step(3);
    chk("hold_an", {4'b0, an_a}, 8'b1110);
    step(1);
    chk("adv_an", {4'b0, an_a}, 8'b1101);
    chk("tens0_lb1", {1'b0, seg_a}, 8'b1111111);
    chk("tens0_lb0", {1'b0, seg_b}, 8'b1000000);

    count = 4'd7;
    mode  = 1'b1;
    frame("f7a");
    frame("f7b");
    chk("u7", {1'b0, seg_a}, 8'b1111000);
    chk("dp7", {7'b0, dp_a}, 8'd1);
    wait_an("w7_1", 4'b1101);
    chk("t7", {1'b0, seg_a}, 8'b1111111);
    wait_an("w7_2", 4'b1011);
    chk("s7", {1'b0, seg_a}, 8'b1111111);
    wait_an("w7_3", 4'b0111);
    chk("m7", {1'b0, seg_a}, 8'b1000001);

    count = 4'd12;
    mode  = 1'b0;
    frame("f12");
    chk("u12", {1'b0, seg_a}, 8'b0100100);
    wait_an("w12_1", 4'b1101);
    chk("t12", {1'b0, seg_a}, 8'b1111001);
    chk("t12_b", {1'b0, seg_b}, 8'b1111001);
    wait_an("w12_3", 4'b0111);
    chk("m12", {1'b0, seg_a}, 8'b0100001);

    count = 4'd3;
    mode  = 1'b1;
    frame("f3");
    chk("u3", {1'b0, seg_a}, 8'b0110000);
    count = 4'd13;
    wait_an("w3_1", 4'b1101);
    chk("t3_hold", {1'b0, seg_a}, 8'b1111111);
    count = 4'd9;
    wait_an("w3_2", 4'b1011);
    chk("s3_hold", {1'b0, seg_a}, 8'b1111111);
    wait_an("w3_3", 4'b0111);
    chk("m3_hold", {1'b0, seg_a}, 8'b1000001);
    wait_an("w9_0", 4'b1110);
    chk("u9", {1'b0, seg_a}, 8'b0010000);

    wait_an("wen_1", 4'b1101);
    step(1);
    enable = 1'b0;
    step(1);
    chk("dis_an", {4'b0, an_a}, 8'b1111);
    chk("dis_seg", {1'b0, seg_a}, 8'b1111111);
    step(9);
    chk("dis_an2", {4'b0, an_a}, 8'b1111);
    enable = 1'b1;
    step(1);
    chk("reen_an", {4'b0, an_a}, {4'b0, exp_an()});
    frame("fen");
    chk("reen_u9", {1'b0, seg_a}, 8'b0010000);

    count = 4'd5;
    frame("f5");
    chk("u5_b", {1'b0, seg_b}, 8'b0010010);
    chk("u5_a", {1'b0, seg_a}, 8'b0010010);
    wait_an("w5_1", 4'b1101);
    chk("t5_b", {1'b0, seg_b}, 8'b1000000);
    chk("t5_a", {1'b0, seg_a}, 8'b1111111);

    mode = 1'b0;
    wait_an("w5_2", 4'b1011);
    step(1);
    reset = 1'b1;
    step(1);
    chk("mrst_an", {4'b0, an_a}, 8'b1111);
    chk("mrst_seg", {1'b0, seg_a}, 8'b1111111);
    chk("mrst_dp", {7'b0, dp_a}, 8'd1);
    chk("mrst_seg_b", {1'b0, seg_b}, 8'b1111111);
    reset = 1'b0;
    step(1);
    chk("mrel_an", {4'b0, an_a}, 8'b1110);
    chk("mrel_seg", {1'b0, seg_a}, 8'b1000000);
    chk("mrel_seg_b", {1'b0, seg_b}, 8'b1000000);
    wait_an("wm_3", 4'b0111);
    chk("mrel_mode", {1'b0, seg_a}, 8'b1000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit up/down counter value.
- Shows the value as two decimal digits on a 4-digit, common-anode, time-multiplexed 7-segment display, with a direction glyph ('U' or 'd') on the leftmost digit.
- Samples count/mode only at frame boundaries, so the digits in one frame always come from one coherent snapshot.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame); must be >= 2.
- LEADING_BLANK, 1, 1 = tens digit blank when value < 10; 0 = show '0'.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- count  input  4  counter value, 0..15, unsigned.
- mode  input  1  counter direction; 1 = up, 0 = down.
- enable  input  1  1 = display on; 0 = all digits dark.
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- dp  output  1  decimal point, active-low; held 1 (off).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Prescaler:
  - Counter width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1, then wraps.
  - tick = 1 for one cycle when prescaler == REFRESH_DIV-1.
- Scan index:
  - 2-bit register, advances 0->1->2->3->0 on each tick; wraps modulo 4.
- Snapshot latch:
  - On the tick where scan == 3 (the 3->0 transition), register snap_count <= count and snap_mode <= mode.
  - No sampling at any other time.
  - A change to count/mode mid-frame is not displayed until the next frame boundary.
- Digit content, from scan and snapshot:
  - scan 0: units digit = snap_count mod 10.
  - scan 1: tens digit = 1 if snap_count >= 10; else blank if LEADING_BLANK = 1, or '0' if LEADING_BLANK = 0.
  - scan 2: blank.
  - scan 3: 'U' if snap_mode = 1, else 'd'.
- Glyph codes, {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 5 = 0010010, 7 = 1111000
  - U = 1000001, d = 0100001, blank = 1111111
  - Remaining digits 3, 4, 6, 8, 9 use standard encodings.
- Outputs:
  - seg, an and dp are registered: they reflect the scan/snapshot state one cycle later.
  - an = ~(1 << scan) when enable = 1. Exactly one anode is low at a time.
- enable = 0:
  - Next cycle: an = 1111, seg = 1111111.
  - Prescaler, scan and snapshot keep running.
  - Re-enabling resumes at the current scan slot, with no reset of the frame.
- Reset (synchronous; also when asserted mid-frame):
  - prescaler = 0, scan = 0, snap_count = 0, snap_mode = 1.
  - an = 1111, seg = 1111111, dp = 1.
  - First cycle after reset deasserts: outputs show digit 0 of value 0 (an = 1110, seg = 1000000).
- Latency: a count change appears at most 4*REFRESH_DIV + 2 cycles later.
- Simultaneous events: when tick coincides with a count change, the value present at that clk edge is captured.
- Arithmetic:
  - Tens/units derived by compare-and-subtract against 10; no division.
  - Input range 0..15 covers all cases, so no overflow handling.

Decomposition:
- Shared package:
  - 7-bit glyph constants: SEG_0..SEG_9, SEG_U, SEG_D, SEG_BLANK.
  - Digit slot constants: DIG_UNITS = 0, DIG_TENS = 1, DIG_SPARE = 2, DIG_MODE = 3.
  - Anode-off constant: 4'b1111.
- Sub-module: seg7_glyph_decode, purely combinational; 4-bit glyph code in, 7-bit active-low segments out. Reused by future display blocks.

Test Plan (REFRESH_DIV = 4 in simulation):
- Reset: hold reset 3 cycles -> an = 1111, seg = 1111111, dp = 1. Release -> next cycle an = 1110, seg = 1000000; scan advances every 4 cycles.
- count = 7, mode = 1, held over 2 frames -> second frame shows:
  - an0: seg 1111000
  - an1: seg 1111111
  - an2: seg 1111111
  - an3: seg 1000001
- count = 12, mode = 0 -> next full frame shows:
  - an0: seg 0100100
  - an1: seg 1111001
  - an3: seg 0100001
- Mid-frame change: count 3 -> 9 while scan = 1 -> remaining slots of that frame still show 3. Digit 9 first appears on an0 of the following frame.
- enable = 0 for 10 cycles mid-frame -> an = 1111 from the next cycle. On re-enable, an matches the free-running scan position; snapshot is unchanged.
- LEADING_BLANK = 0, count = 5 -> an1 seg 1000000, an0 seg 0010010. Then reset asserted mid-frame -> next cycle all outputs off, snapshot = 0.
